pj_exibe_sequencia: RTL and testbench

- Presenter side of the MindFocus game: reads the stored sequence out of the game memory and flashes it on the LEDs for the player to memorise.
- It is the counterpart of the player-input/compare datapath, which reads the same memory back against the buttons.
- It sits between the control unit (start/stop, sequence length) and the synchronous 16x4 sequence memory.
- It emits one pulse when the whole prefix 0..limite has been shown.

---
 rtl/pj_pkg.sv | 17 +
 rtl/contador_m.sv | 20 ++
 rtl/pj_exibe_sequencia.sv | 105 ++++++++++
 tb/tb_pj_exibe_sequencia.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pj_pkg.sv
// Shared definitions for the MindFocus sequence presenter: FSM state codes and item width.
package pj_pkg;

    localparam int unsigned W_ITEM = 4;

    // Encodings double as the db_estado debug codes.
    typedef enum logic [3:0] {
        E_INICIAL = 4'd0,
        E_BUSCA   = 4'd1,
        E_ESPERA  = 4'd2,
        E_ACENDE  = 4'd3,
        E_APAGA   = 4'd4,
        E_PROXIMO = 4'd5,
        E_FIM     = 4'd6
    } estado_t;

endpackage

// File: rtl/contador_m.sv
// Up-counter with synchronous reset, synchronous clear and count enable; used as the on/off timer.
module contador_m #(
    parameter int unsigned N = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera_s,
    input  logic         conta,
    output logic [N-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset || zera_s) begin
            q <= '0;
        end else if (conta) begin
            q <= q + N'(1);
        end
    end

endmodule

// File: rtl/pj_exibe_sequencia.sv
// Presenter: walks the stored sequence 0..limite out of the external sync ROM and flashes
// each item on the LEDs, then pulses fim_exibicao once.
module pj_exibe_sequencia
    import pj_pkg::*;
#(
    parameter int unsigned T_ACESO   = 1000,
    parameter int unsigned T_APAGADO = 250,
    parameter int unsigned N_TIMER   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              parar,
    input  logic [3:0]        limite,
    input  logic [W_ITEM-1:0] dado_memoria,
    output logic [3:0]        endereco,
    output logic [W_ITEM-1:0] leds,
    output logic              exibindo,
    output logic              fim_exibicao,
    output logic [3:0]        db_estado
);

    localparam logic [N_TIMER-1:0] TC_ACESO   = N_TIMER'(T_ACESO - 1);
    localparam logic [N_TIMER-1:0] TC_APAGADO = N_TIMER'(T_APAGADO - 1);

    estado_t             estado;
    logic [W_ITEM-1:0]   reg_item;
    logic [3:0]          limite_reg;
    logic [N_TIMER-1:0]  timer;
    logic                fim_aceso;
    logic                fim_apagado;
    logic                zera_s;
    logic                conta;

    assign fim_aceso   = (timer == TC_ACESO);
    assign fim_apagado = (timer == TC_APAGADO);
    assign conta       = (estado == E_ACENDE) || (estado == E_APAGA);
    // Timer restarts from 0 on entry to both ACENDE and APAGA.
    assign zera_s      = (estado == E_INICIAL) || (estado == E_ESPERA) ||
                         ((estado == E_ACENDE) && fim_aceso);

    contador_m #(
        .N (N_TIMER)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .zera_s (zera_s),
        .conta  (conta),
        .q      (timer)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado       <= E_INICIAL;
            endereco     <= '0;
            limite_reg   <= '0;
            reg_item     <= '0;
            exibindo     <= 1'b0;
            fim_exibicao <= 1'b0;
        end else begin
            fim_exibicao <= 1'b0;
            if (parar && (estado != E_INICIAL)) begin
                estado   <= E_INICIAL;
                exibindo <= 1'b0;
            end else begin
                unique case (estado)
                    E_INICIAL: begin
                        if (iniciar) begin
                            limite_reg <= limite;
                            endereco   <= '0;
                            exibindo   <= 1'b1;
                            estado     <= E_BUSCA;
                        end
                    end
                    E_BUSCA:  estado <= E_ESPERA;
                    E_ESPERA: begin
                        reg_item <= dado_memoria;
                        estado   <= E_ACENDE;
                    end
                    E_ACENDE: if (fim_aceso) estado <= E_APAGA;
                    E_APAGA:  if (fim_apagado) estado <= E_PROXIMO;
                    E_PROXIMO: begin
                        // Last-item check precedes the increment, so 15 never wraps.
                        if (endereco == limite_reg) begin
                            fim_exibicao <= 1'b1;
                            estado       <= E_FIM;
                        end else begin
                            endereco <= endereco + 4'd1;
                            estado   <= E_BUSCA;
                        end
                    end
                    E_FIM: begin
                        exibindo <= 1'b0;
                        estado   <= E_INICIAL;
                    end
                    default: estado <= E_INICIAL;
                endcase
            end
        end
    end

    assign leds      = (estado == E_ACENDE) ? reg_item : '0;
    assign db_estado = estado;

endmodule

// File: tb/tb_pj_exibe_sequencia.sv
// Self-checking bench for pj_exibe_sequencia against a cycle-position model of a display run.
module tb_pj_exibe_sequencia;

    localparam int TA  = 4;
    localparam int TB  = 2;
    localparam int PER = 3 + TA + TB;

    logic       clock = 1'b0;
    logic       reset, iniciar, parar;
    logic [3:0] limite, dado_memoria, endereco, leds, db_estado;
    logic       exibindo, fim_exibicao;
    logic [3:0] rom [16];
    int         checks = 0;
    int         errors = 0;

    always #5 clock = ~clock;

    always_ff @(posedge clock) dado_memoria <= rom[endereco];

    pj_exibe_sequencia #(
        .T_ACESO   (TA),
        .T_APAGADO (TB),
        .N_TIMER   (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .parar        (parar),
        .limite       (limite),
        .dado_memoria (dado_memoria),
        .endereco     (endereco),
        .leds         (leds),
        .exibindo     (exibindo),
        .fim_exibicao (fim_exibicao),
        .db_estado    (db_estado)
    );

    // Expected {db_estado, endereco, leds, exibindo, fim_exibicao} in cycle c after the start edge.
    function automatic logic [13:0] exp_vec(input int l, input int c);
        int last = PER * (l + 1) + 1;
        int p, i;
        logic [3:0] st, en, ld;
        i  = (c - 1) / PER;
        p  = (c - 1) % PER;
        en = 4'((i > l) ? l : i);
        ld = 4'd0;
        if (c == last)      st = 4'd6;
        else if (c > last)  st = 4'd0;
        else if (p == 0)    st = 4'd1;
        else if (p == 1)    st = 4'd2;
        else if (p < 2 + TA) begin
            st = 4'd3;
            ld = rom[i];
        end
        else if (p < 2 + TA + TB) st = 4'd4;
        else                      st = 4'd5;
        return {st, en, ld, (c <= last), (c == last)};
    endfunction

    function automatic logic [13:0] obs_vec();
        return {db_estado, endereco, leds, exibindo, fim_exibicao};
    endfunction

    task automatic rom_default();
        for (int a = 0; a < 16; a++) rom[a] = 4'(1 << (a % 4));
    endtask

    task automatic start_run(input int l);
        @(negedge clock);
        iniciar = 1'b1;
        limite  = 4'(l);
        @(posedge clock);
        #1 iniciar = 1'b0;
        parar = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] o;
        reset = 1'b1; iniciar = 1'b1; parar = 1'b1; limite = 4'd7;
        repeat (2) @(posedge clock);
        @(negedge clock);
        o = obs_vec();
        checks++;
        if (o !== 14'h0) begin
            errors++;
            $display("FAIL reset_state got %h exp %h", o, 14'h0);
        end
        reset = 1'b0; iniciar = 1'b0; parar = 1'b0;
    endtask

    task automatic test_single();
        logic [13:0] o, e;
        start_run(0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            o = obs_vec(); e = exp_vec(0, c);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL single c=%0d got %h exp %h", c, o, e);
            end
        end
    endtask

    task automatic test_sequence();
        logic [13:0] o, e;
        start_run(2);
        for (int c = 1; c <= PER * 3 + 3; c++) begin
            @(negedge clock);
            o = obs_vec(); e = exp_vec(2, c);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL sequence c=%0d got %h exp %h", c, o, e);
            end
        end
    endtask

    task automatic test_parar();
        logic [13:0] o, e;
        logic [9:0]  m;
        start_run(3);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            o = obs_vec(); e = exp_vec(3, c);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL parar_pre c=%0d got %h exp %h", c, o, e);
            end
        end
        parar = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            m = {db_estado, leds, exibindo, fim_exibicao};
            checks++;
            if (m !== 10'h0) begin
                errors++;
                $display("FAIL parar_idle c=%0d got %h exp %h", c, m, 10'h0);
            end
        end
        // parar still high together with iniciar in INICIAL: start must win.
        start_run(1);
        for (int c = 1; c <= PER * 2 + 2; c++) begin
            @(negedge clock);
            o = obs_vec(); e = exp_vec(1, c);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL parar_restart c=%0d got %h exp %h", c, o, e);
            end
        end
    endtask

    task automatic test_noise();
        logic [13:0] o, e;
        start_run(2);
        for (int c = 1; c <= PER * 3 + 3; c++) begin
            @(negedge clock);
            o = obs_vec(); e = exp_vec(2, c);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL noise c=%0d got %h exp %h", c, o, e);
            end
            iniciar = (c < PER * 3 - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            limite  = (c == 10) ? 4'd5 : 4'($urandom_range(0, 15));
        end
        iniciar = 1'b0;
    endtask

    task automatic test_limite15();
        logic [13:0] o, e;
        start_run(15);
        for (int c = 1; c <= PER * 16 + 3; c++) begin
            @(negedge clock);
            o = obs_vec(); e = exp_vec(15, c);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL limite15 c=%0d got %h exp %h", c, o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] o, e;
        start_run(3);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            o = obs_vec(); e = exp_vec(3, c);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_mid_pre c=%0d got %h exp %h", c, o, e);
            end
        end
        reset = 1'b1; iniciar = 1'b1; parar = 1'b1;
        @(negedge clock);
        reset = 1'b0; iniciar = 1'b0; parar = 1'b0;
        for (int c = 0; c < 6; c++) begin
            o = obs_vec();
            checks++;
            if (o !== 14'h0) begin
                errors++;
                $display("FAIL reset_mid c=%0d got %h exp %h", c, o, 14'h0);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] o, e;
        @(negedge clock);
        iniciar = 1'b1;
        limite  = 4'd0;
        @(posedge clock);
        for (int c = 1; c <= 23; c++) begin
            @(negedge clock);
            o = obs_vec();
            e = (c <= PER + 2) ? exp_vec(0, c) : exp_vec(0, c - (PER + 2));
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL back_to_back c=%0d got %h exp %h", c, o, e);
            end
            if (c == 2 * (PER + 2)) iniciar = 1'b0;
        end
        iniciar = 1'b0;
    endtask

    task automatic test_random();
        logic [13:0] o, e;
        int l;
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < 16; a++) rom[a] = 4'($urandom_range(0, 15));
            rom[0] = (r == 0) ? 4'd0 : rom[0];
            l = $urandom_range(0, 4);
            start_run(l);
            for (int c = 1; c <= PER * (l + 1) + 2; c++) begin
                @(negedge clock);
                o = obs_vec(); e = exp_vec(l, c);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL random r=%0d l=%0d c=%0d got %h exp %h", r, l, c, o, e);
                end
                iniciar = (c < PER * (l + 1) - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                limite  = 4'($urandom_range(0, 15));
            end
            iniciar = 1'b0;
        end
        rom_default();
    endtask

    initial begin
        rom_default();
        reset = 1'b0; iniciar = 1'b0; parar = 1'b0; limite = 4'd0;
        test_reset();
        test_single();
        test_sequence();
        test_parar();
        test_noise();
        test_limite15();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
